// File: rtl/adder_sched_pkg.sv
// adder_sched_pkg: lane-mode encodings and lane-mask helpers shared by the
// adder scheduler. DATA_W_DEF follows the global `DATA_LEN define.
// Optional build macro used by this slice: ADDER_SCHED_PRIO_EN (see adder_rr_arb).
`ifndef DATA_LEN
`define DATA_LEN 64
`endif

package adder_sched_pkg;

    localparam int DATA_W_DEF = `DATA_LEN;

    typedef enum logic [1:0] {
        MODE_B8   = 2'b00,
        MODE_B16  = 2'b01,
        MODE_B32  = 2'b10,
        MODE_FULL = 2'b11
    } lane_mode_e;

    // True where bit i is the top bit of a lane (carry must not cross it),
    // except the adder's own MSB which feeds the carry-out slot.
    function automatic logic lane_break(input int i, input int lb, input int width);
        return ((i + 1) % lb == 0) && (i < width - 1);
    endfunction

    // One bit of the carry-propagate lane mask. Arguments i/width are
    // elaboration constants at every call site, so this folds to a mode mux.
    function automatic logic mask_bit(input logic [1:0] mode, input int i, input int width);
        logic brk;
        case (mode)
            MODE_B8:  brk = lane_break(i, 8, width);
            MODE_B16: brk = lane_break(i, 16, width);
            MODE_B32: brk = lane_break(i, 32, width);
            default:  brk = 1'b0;   // full width: no internal lane boundary
        endcase
        return !brk;
    endfunction

endpackage

// File: rtl/adder_rr_arb.sv
// adder_rr_arb: NREQ-way arbiter for the shared adder. Grant is combinational;
// the round-robin pointer advances to winner+1 only on an accepted grant.
// ADDER_SCHED_PRIO_EN: fixed priority (index 0 highest), pointer removed.
module adder_rr_arb #(
    parameter int NREQ  = 2,
    parameter int SEL_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             accept,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] gnt_idx
);

`ifdef ADDER_SCHED_PRIO_EN

    // Lowest requesting index wins; scan high-to-low so the last hit sticks.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int r = NREQ - 1; r >= 0; r--) begin
            if (req[r]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(r);
            end
        end
    end

`else

    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  ptr_nxt;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;

    // Rotate requests so the pointer position is bit 0, then pick the first hit.
    always_comb begin
        int s;
        s       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        dbl     = {req, req};
        rot     = NREQ'(dbl >> ptr);
        for (int o = NREQ - 1; o >= 0; o--) begin
            if (rot[o]) begin
                s = int'(ptr) + o;
                if (s >= NREQ) s = s - NREQ;
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(s);
            end
        end
    end

    // Next pointer: one past the current winner, wrapping at NREQ.
    always_comb begin
        int n;
        n = int'(gnt_idx) + 1;
        if (n >= NREQ) n = 0;
        ptr_nxt = SEL_W'(n);
    end

    // Pointer only moves when the grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      ptr <= '0;
        else if (accept) ptr <= ptr_nxt;
    end

`endif

endmodule

// File: rtl/adder_sched_ctrl.sv
// adder_sched_ctrl: arbitrates NREQ requesters onto the shared pipelined
// prefix adder, generates the per-op SIMD lane mask, carries owner/mask down
// LAT stages and returns a one-hot rsp_valid to the owner. Back-pressure from
// the owner of the last stage freezes the whole pipe (global stall).
// ADDER_SCHED_PRIO_EN: fixed-priority arbitration instead of round robin.
module adder_sched_ctrl
    import adder_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREQ   = 2,
    parameter int LAT    = 2,
    parameter int SEL_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [2*NREQ-1:0]         req_mode,
    input  logic [NREQ-1:0]           req_sub,
    output logic [NREQ-1:0]           req_ready,
    output logic                      adder_issue,
    output logic [SEL_W-1:0]          adder_sel,
    output logic                      adder_sub,
    output logic [LAT-1:0]            stage_en,
    output logic [LAT*(DATA_W+1)-1:0] stage_mask,
    output logic [NREQ-1:0]           rsp_valid,
    input  logic [NREQ-1:0]           rsp_ready
);

    typedef struct packed {
        logic [SEL_W-1:0] own;
        logic [DATA_W:0]  msk;
    } stage_t;

    logic [LAT-1:0]   vld_pipe;     // per-stage occupancy
    stage_t [LAT-1:0] stg;
    logic [NREQ-1:0]  own_hot;
    logic             stall;
    logic             run;
    logic             hs;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [1:0]       mode_g;
    logic             sub_g;
    logic [DATA_W:0]  mask_new;

    adder_rr_arb #(.NREQ(NREQ), .SEL_W(SEL_W)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .accept  (hs),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // Decode last-stage owner; stall when it holds a result nobody takes.
    always_comb begin
        own_hot = '0;
        for (int r = 0; r < NREQ; r++)
            own_hot[r] = (stg[LAT-1].own == SEL_W'(r));
        stall     = vld_pipe[LAT-1] & ~|(own_hot & rsp_ready);
        run       = rst_n & ~stall;
        hs        = gnt_vld & run;
        rsp_valid = own_hot & {NREQ{vld_pipe[LAT-1]}};
    end

    // Operand-side mux of the winner's mode/sub and its lane mask.
    always_comb begin
        mode_g = '0;
        sub_g  = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            if (gnt_idx == SEL_W'(r)) begin
                mode_g = req_mode[2*r +: 2];
                sub_g  = req_sub[r];
            end
        end
        mask_new = '0;
        for (int i = 0; i <= DATA_W; i++)
            mask_new[i] = mask_bit(mode_g, i, DATA_W);
    end

    // Issue-side outputs; everything idles at zero without a handshake.
    always_comb begin
        req_ready = '0;
        for (int r = 0; r < NREQ; r++)
            req_ready[r] = hs && (gnt_idx == SEL_W'(r));
        adder_issue = hs;
        adder_sel   = hs ? gnt_idx : '0;
        adder_sub   = hs & sub_g;
        stage_en    = {LAT{run}};
    end

    // Empty stages drive an all-zero mask.
    always_comb begin
        stage_mask = '0;
        for (int k = 0; k < LAT; k++)
            stage_mask[k*(DATA_W+1) +: DATA_W+1] = vld_pipe[k] ? stg[k].msk : '0;
    end

    // Pipeline shift: bubbles advance too; stall freezes every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            stg      <= '0;
        end else if (!stall) begin
            for (int k = LAT - 1; k >= 1; k--) begin
                vld_pipe[k] <= vld_pipe[k-1];
                stg[k]      <= stg[k-1];
            end
            vld_pipe[0] <= hs;
            stg[0].own  <= hs ? gnt_idx : '0;
            stg[0].msk  <= hs ? mask_new : '0;
        end
    end

endmodule

// File: doc/adder_sched_ctrl.md
Name: adder_sched_ctrl

Overview:
- Sequencing and arbitration controller for the shared pipelined parallel-prefix adder (generate/propagate tree with per-stage lane masks).
- Shares the adder between NREQ requesters, e.g. integer ALU and address generator.
- Generates the SIMD lane mask for each operation and carries it down the pipeline with the operation.
- Tracks in-flight ownership and returns results with a valid/ready handshake; applies a global stall on back-pressure.

Parameters:
- DATA_W, 64: adder width; mask vectors are DATA_W+1 bits (top bit is the carry-out slot).
- NREQ, 2: number of requesters, 2..4.
- LAT, 2: adder pipeline depth in register stages, 1..6.
- SEL_W, 2: width of the owner index; must be at least clog2(NREQ).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  operation request per requester.
- req_mode  in  2*NREQ  lane mode per requester: 00 = 8-bit, 01 = 16-bit, 10 = 32-bit, 11 = DATA_W.
- req_sub  in  NREQ  subtract (invert b, cin = 1) per requester.
- req_ready  out  NREQ  request accepted this cycle.
- adder_issue  out  1  operand capture strobe for adder stage 0.
- adder_sel  out  SEL_W  operand mux select (granted requester).
- adder_sub  out  1  subtract control for the issued operation.
- stage_en  out  LAT  pipeline register enables.
- stage_mask  out  LAT*(DATA_W+1)  lane mask for each stage; slice k goes to stage k.
- rsp_valid  out  NREQ  result valid, one-hot to the owner.
- rsp_ready  in  NREQ  owner accepts the result.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - All occupancy bits cleared; round-robin pointer = 0.
  - All outputs = 0, including stage_mask = 0 and rsp_valid = 0.
- Per-stage state: occ[k] (occupied), own[k] (owner index), msk[k] (lane mask).
- stall = occ[LAT-1] & !rsp_ready[own[LAT-1]].
  - While stall: stage_en = 0, req_ready = 0, adder_issue = 0, no state moves.
  - Not stalled: stage_en = all ones, so bubbles advance too and the pipeline does not collapse.
- Arbitration:
  - Round-robin over req_valid, starting at the pointer.
  - The winner g gets req_ready[g] = 1 only when !stall, combinationally in the same cycle.
  - On handshake: adder_issue = 1, adder_sel = g, adder_sub = req_sub[g]; the pointer moves to g+1 mod NREQ.
  - The pointer does not move when there is no handshake.
- Issue registers into stage 0 on the same edge:
  - occ[0] = 1, own[0] = g.
  - msk[0] = lane mask of req_mode[g].
  - Mask rule: bit i = 0 iff (i+1) mod lane_bits == 0 and i < DATA_W-1; every other bit = 1.
  - Mode 11 gives all ones. Bit DATA_W is always 1.
- Pipeline flow and mask output:
  - Each unstalled cycle, stage k+1 takes the contents of stage k.
  - Stage 0 takes the new issue, or empty when there is no issue.
  - stage_mask slice k = msk[k] when occ[k], otherwise 0, so empty stages produce zeros.
- Latency: an op issued at cycle t has rsp_valid[owner] = 1 from cycle t+LAT; minimum issue-to-response = LAT cycles.
- Response: rsp_valid = onehot(own[LAT-1]) & occ[LAT-1]. The handshake retires the op when the stage advances.
- Throughput: 1 op per cycle when rsp_ready is held high.
- Simultaneous response handshake and new issue in the same cycle: both happen.
- A requester that drops req_valid while not granted loses nothing; no request is queued.
- Reset mid-operation: all in-flight ops are discarded and no rsp_valid is produced after reset.

Optional Feature:
- ADDER_SCHED_PRIO_EN
  - Defined: requester 0 has fixed highest priority, with fixed priority by index after it; the round-robin pointer is removed.
  - Undefined: round robin as specified above.

Decomposition:
- Shared package/define file:
  - lane-mode encodings: MODE_B8, MODE_B16, MODE_B32, MODE_FULL.
  - mask-generation function.
  - DATA_W, taken from the global data-length define.
- Natural sub-module: adder_rr_arb (NREQ-way round-robin arbiter with pointer, combinational grant and update-on-accept). The fixed-priority variant lives inside it under the macro.

Test Plan:
- Reset: assert rst_n = 0 mid-flight with 2 ops in the pipe -> all outputs 0 immediately; no rsp_valid after release.
- Single op:
  - Stimulus: LAT = 2, req0 mode 01 at cycle 0, rsp_ready = 1.
  - Expected: adder_issue at cycle 0; stage_mask slice0 cycle 1 = bits 15, 31, 47 cleared; rsp_valid = 01 at cycle 2, single cycle.
- Contention:
  - Stimulus: both requesters valid every cycle.
  - Expected: grants alternate 0, 1, 0, 1; rsp_valid alternates 01, 10 LAT cycles later. With ADDER_SCHED_PRIO_EN, req0 is granted every cycle.
- Back-pressure:
  - Stimulus: rsp_ready[0] = 0 for 3 cycles with a full pipe.
  - Expected: stage_en = 0, req_ready = 0, rsp_valid held for 3 cycles; flow resumes without loss or duplication.
- Back-to-back issue plus retire:
  - Stimulus: new issue in the same cycle as a response handshake.
  - Expected: both complete; throughput of 1 op per cycle sustained over 20 ops.
- Mode sweep: issue mode 00/01/10/11 -> masks match the rule; mode 11 gives all ones; bit 64 is always 1.
